// File: rtl/sqrt_share_pkg.sv
// Shared types and helpers for the sqrt_share_ctrl slice: controller state
// encoding and requester-index width.
package sqrt_share_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } share_state_t;

  localparam int unsigned FaultW = 8;

  // Width of a requester index; never zero so a single requester still gets a bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sqrt_share_ctrl_if.sv
// Requester-side request/response bundle of the shared sqrt controller.
// The controller takes the slave modport; requesters drive the master side.
interface sqrt_share_ctrl_if #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned IN_WIDTH  = 32,
   parameter int unsigned OUT_WIDTH = IN_WIDTH / 2
);

   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ*IN_WIDTH-1:0] req_x;
   logic [NUM_REQ-1:0]          req_ready;
   logic [NUM_REQ-1:0]          resp_valid;
   logic [NUM_REQ-1:0]          resp_ready;
   logic [OUT_WIDTH-1:0]        resp_y;
   logic                        resp_neg;
   logic                        resp_err;

   modport master (
      output req_valid, req_x, resp_ready,
      input  req_ready, resp_valid, resp_y, resp_neg, resp_err
   );

   modport slave (
      input  req_valid, req_x, resp_ready,
      output req_ready, resp_valid, resp_y, resp_neg, resp_err
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above
// ptr_i, wrapping around, as a one-hot vector plus its index.
module rr_arbiter #(
   parameter int unsigned N   = 4,
   parameter int unsigned IdW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]   req_i,
   input  logic [IdW-1:0] ptr_i,
   output logic [N-1:0]   grant_o,
   output logic [IdW-1:0] grant_idx_o
);

   int j;

   // Scan from the farthest slot down to ptr_i so the nearest request wins.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      j           = 0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         j = (int'(ptr_i) + k) % int'(N);
         if (req_i[j]) begin
            grant_o     = '0;
            grant_o[j]  = 1'b1;
            grant_idx_o = IdW'(j);
         end
      end
   end

endmodule

// File: rtl/sqrt_share_ctrl.sv
// Shares one cordic_sqrt core among NUM_REQ requesters: round-robin accept,
// issue, wait for done or timeout, then return the result to the requester.
module sqrt_share_ctrl
   import sqrt_share_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned IN_WIDTH  = 32,
   parameter int unsigned OUT_WIDTH = IN_WIDTH / 2,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   sqrt_share_ctrl_if.slave     share_io,
   output logic                 sq_start_o,
   output logic [IN_WIDTH-1:0]  sq_x_o,
   input  logic [OUT_WIDTH-1:0] sq_y_i,
   input  logic                 sq_neg_i,
   input  logic                 sq_done_i,
   output logic                 sq_kill_o,
   output logic [FaultW-1:0]    fault_cnt_o
);

   localparam int unsigned IdW  = id_w(NUM_REQ);
   localparam int unsigned TmoW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TmoW-1:0] TmoLoad = TmoW'(TIMEOUT - 1);

   share_state_t         state_q, state_d;
   logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IdW-1:0]       cur_id_q, cur_id_d;
   logic [IN_WIDTH-1:0]  sq_x_q, sq_x_d;
   logic [TmoW-1:0]      tmo_q, tmo_d;
   logic [OUT_WIDTH-1:0] resp_y_q, resp_y_d;
   logic                 resp_neg_q, resp_neg_d;
   logic                 resp_err_q, resp_err_d;
   logic                 kill_q, kill_d;
   logic [FaultW-1:0]    fault_q, fault_d;

   logic [NUM_REQ-1:0]   grant;
   logic [IdW-1:0]       grant_idx;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   resp_valid;

   rr_arbiter #(
      .N   (NUM_REQ),
      .IdW (IdW)
   ) u_arb (
      .req_i       (share_io.req_valid),
      .ptr_i       (rr_ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      cur_id_d   = cur_id_q;
      sq_x_d     = sq_x_q;
      tmo_d      = tmo_q;
      resp_y_d   = resp_y_q;
      resp_neg_d = resp_neg_q;
      resp_err_d = resp_err_q;
      kill_d     = 1'b0;
      fault_d    = fault_q;
      req_ready  = '0;
      resp_valid = '0;

      unique case (state_q)
         StIdle: begin
            req_ready = grant;
            if (|grant) begin
               sq_x_d   = share_io.req_x[int'(grant_idx) * int'(IN_WIDTH) +: IN_WIDTH];
               cur_id_d = grant_idx;
               rr_ptr_d = (int'(grant_idx) == int'(NUM_REQ) - 1) ? '0 : grant_idx + 1'b1;
               state_d  = StIssue;
            end
         end
         StIssue: begin
            tmo_d   = TmoLoad;
            state_d = StWait;
         end
         StWait: begin
            // done has priority over an expiring timeout in the same cycle
            if (sq_done_i) begin
               resp_y_d   = sq_y_i;
               resp_neg_d = sq_neg_i;
               resp_err_d = 1'b0;
               state_d    = StResp;
            end else if (tmo_q == '0) begin
               kill_d     = 1'b1;
               resp_y_d   = '0;
               resp_neg_d = 1'b0;
               resp_err_d = 1'b1;
               fault_d    = (fault_q == '1) ? fault_q : fault_q + 1'b1;
               state_d    = StResp;
            end else begin
               tmo_d = tmo_q - 1'b1;
            end
         end
         StResp: begin
            resp_valid = NUM_REQ'(1) << cur_id_q;
            if (share_io.resp_ready[cur_id_q]) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         cur_id_q   <= '0;
         sq_x_q     <= '0;
         tmo_q      <= '0;
         resp_y_q   <= '0;
         resp_neg_q <= 1'b0;
         resp_err_q <= 1'b0;
         kill_q     <= 1'b0;
         fault_q    <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         cur_id_q   <= cur_id_d;
         sq_x_q     <= sq_x_d;
         tmo_q      <= tmo_d;
         resp_y_q   <= resp_y_d;
         resp_neg_q <= resp_neg_d;
         resp_err_q <= resp_err_d;
         kill_q     <= kill_d;
         fault_q    <= fault_d;
      end
   end

   // Kill is registered so the core reset sees a clean pulse, aligned with resp_err.
   assign sq_kill_o           = kill_q;
   assign sq_start_o          = (state_q == StIssue);
   assign sq_x_o              = sq_x_q;
   assign fault_cnt_o         = fault_q;
   assign share_io.req_ready  = req_ready;
   assign share_io.resp_valid = resp_valid;
   assign share_io.resp_y     = resp_y_q;
   assign share_io.resp_neg   = resp_neg_q;
   assign share_io.resp_err   = resp_err_q;

endmodule

// File: tb/tb_sqrt_share_ctrl.sv
// Randomised scoreboard bench for sqrt_share_ctrl with a behavioural core
// model (normal, hung, and done-at-timeout modes).
module tb_sqrt_share_ctrl;

   localparam int NR  = 4;
   localparam int IW  = 32;
   localparam int OW  = 16;
   localparam int TMO = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sqrt_share_ctrl_if #(.NUM_REQ(NR), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

   logic          sq_start, sq_neg, sq_done, sq_kill;
   logic [IW-1:0] sq_x;
   logic [OW-1:0] sq_y;
   logic [7:0]    fault_cnt;

   sqrt_share_ctrl #(
      .NUM_REQ   (NR),
      .IN_WIDTH  (IW),
      .OUT_WIDTH (OW),
      .TIMEOUT   (TMO)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .share_io    (bus),
      .sq_start_o  (sq_start),
      .sq_x_o      (sq_x),
      .sq_y_i      (sq_y),
      .sq_neg_i    (sq_neg),
      .sq_done_i   (sq_done),
      .sq_kill_o   (sq_kill),
      .fault_cnt_o (fault_cnt)
   );

   typedef struct {
      int            id;
      logic [OW-1:0] y;
      bit            neg;
      bit            err;
   } exp_t;

   exp_t        sbq[$];
   int unsigned n_cmp = 0;
   int unsigned n_fail = 0;
   int          cyc = 0;

   bit [NR-1:0]   pend = '0;
   logic [IW-1:0] rx[NR];
   int            gen_mode = 0;    // 0 none, 1 random, 2 always valid
   int            force_mode = 0;  // -1 random, 0 normal, 1 hung core, 2 done at timeout
   int            rr_mode = 0;
   logic [NR-1:0] rr_fixed = '1;
   bit            drive_rst = 1'b1;
   bit            noise_en = 1'b0;

   int            mptr = 0;
   bit            mbusy = 1'b0;
   int            m_id = 0;
   int            m_mode = 0;
   logic [IW-1:0] exp_x = '0;
   int            core_cnt = 0;
   logic [IW-1:0] core_x = '0;
   int            exp_start_cyc = -1;
   int            exp_resp_cyc = -1;
   int            exp_kill_cyc = -1;
   int            exp_fault = 0;

   function automatic logic [OW-1:0] isqrt(input logic [IW-1:0] v);
      longint unsigned r, t, vv;
      r  = 0;
      vv = 64'(v);
      if (v[IW-1]) return '0;
      for (int b = OW - 1; b >= 0; b--) begin
         t = r | (64'd1 << b);
         if (t * t <= vv) r = t;
      end
      return OW'(r);
   endfunction

   function automatic int rr_pick(input bit [NR-1:0] p, input int ptr);
      for (int k = 0; k < NR; k++) begin
         if (p[(ptr + k) % NR]) return (ptr + k) % NR;
      end
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: actual %0h required %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      sbq.delete();
      mbusy         = 1'b0;
      mptr          = 0;
      core_cnt      = 0;
      exp_start_cyc = -1;
      exp_resp_cyc  = -1;
      exp_kill_cyc  = -1;
      exp_fault     = 0;
   endtask

   task automatic step();
      int            g;
      logic [NR-1:0] eg;
      exp_t          e;
      @(negedge clk);
      cyc++;
      rst     = drive_rst;
      sq_done = 1'b0;
      if (core_cnt > 0) begin
         core_cnt--;
         if (core_cnt == 0) begin
            sq_done      = 1'b1;
            sq_y         = isqrt(core_x);
            sq_neg       = core_x[IW-1];
            exp_resp_cyc = cyc + 1;
         end
      end else if (noise_en && !mbusy && $urandom_range(0, 7) == 0) begin
         sq_done = 1'b1;
         sq_y    = OW'($urandom);
         sq_neg  = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < NR; i++) begin
         if (!pend[i] && (gen_mode == 2 || (gen_mode == 1 && $urandom_range(0, 3) == 0))) begin
            pend[i] = 1'b1;
            rx[i]   = $urandom;
         end
         bus.req_valid[i]        = pend[i];
         bus.req_x[i*IW +: IW]   = rx[i];
      end
      bus.resp_ready = (rr_mode != 0) ? NR'($urandom) : rr_fixed;
      #1;
      if (rst) begin
         model_reset();
      end else begin
         eg = '0;
         g  = mbusy ? -1 : rr_pick(pend, mptr);
         if (g >= 0) eg[g] = 1'b1;
         chk("req_ready", 64'(bus.req_ready), 64'(eg));
         if (g >= 0) begin
            m_mode = (force_mode >= 0) ? force_mode :
                     ($urandom_range(0, 9) < 7) ? 0 : ($urandom_range(0, 1) == 0) ? 1 : 2;
            e.id = g;
            if (m_mode == 1) begin
               e.y = '0; e.neg = 1'b0; e.err = 1'b1;
            end else begin
               e.y = isqrt(rx[g]); e.neg = rx[g][IW-1]; e.err = 1'b0;
            end
            sbq.push_back(e);
            m_id          = g;
            exp_x         = rx[g];
            mptr          = (g + 1) % NR;
            pend[g]       = 1'b0;
            mbusy         = 1'b1;
            exp_start_cyc = cyc + 1;
         end
         chk("sq_start", 64'(sq_start), 64'(cyc == exp_start_cyc));
         if (sq_start) begin
            chk("sq_x", 64'(sq_x), 64'(exp_x));
            core_x   = sq_x;
            core_cnt = (m_mode == 0) ? int'($urandom_range(1, OW + 2)) : (m_mode == 2) ? TMO : 0;
            if (m_mode == 1) begin
               exp_kill_cyc = cyc + TMO + 1;
               exp_resp_cyc = cyc + TMO + 1;
            end
         end
         if (cyc == exp_kill_cyc && exp_fault < 255) exp_fault++;
         chk("sq_kill", 64'(sq_kill), 64'(cyc == exp_kill_cyc));
         chk("fault_cnt", 64'(fault_cnt), 64'(exp_fault));
         if (cyc == exp_resp_cyc) begin
            eg = '0;
            eg[m_id] = 1'b1;
            chk("resp_valid_latency", 64'(bus.resp_valid), 64'(eg));
         end
         if (|(bus.resp_valid & bus.resp_ready)) mbusy = 1'b0;
         if (sq_kill) core_cnt = 0;
      end
   endtask

   task automatic drain(input int maxc);
      int n;
      n = 0;
      while ((mbusy || pend != '0 || sbq.size() != 0) && n < maxc) begin
         step();
         n++;
      end
      step();
      if (n >= maxc) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain_timeout: still busy after %0d cycles, required idle", maxc);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
      chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
      chk({tag, "_resp_y"}, 64'(bus.resp_y), 64'd0);
      chk({tag, "_resp_neg"}, 64'(bus.resp_neg), 64'd0);
      chk({tag, "_resp_err"}, 64'(bus.resp_err), 64'd0);
      chk({tag, "_sq_start"}, 64'(sq_start), 64'd0);
      chk({tag, "_sq_x"}, 64'(sq_x), 64'd0);
      chk({tag, "_sq_kill"}, 64'(sq_kill), 64'd0);
      chk({tag, "_fault_cnt"}, 64'(fault_cnt), 64'd0);
   endtask

   // Response monitor: pops the scoreboard on every response handshake and
   // checks that a stalled response holds its data.
   bit            hold_v = 1'b0;
   logic [NR-1:0] hold_rv;
   logic [OW+1:0] hold_d;
   logic [NR-1:0] eoh;
   exp_t          me;

   always @(negedge clk) begin
      #2;
      if (rst) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            chk("hold_valid", 64'(bus.resp_valid), 64'(hold_rv));
            chk("hold_data", 64'({bus.resp_y, bus.resp_neg, bus.resp_err}), 64'(hold_d));
         end
         hold_v = 1'b0;
         if (|bus.resp_valid) begin
            if (|(bus.resp_valid & bus.resp_ready)) begin
               if (sbq.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL resp_unexpected: actual resp_valid %0h, required none", bus.resp_valid);
               end else begin
                  me  = sbq.pop_front();
                  eoh = '0;
                  eoh[me.id] = 1'b1;
                  chk("resp_id", 64'(bus.resp_valid), 64'(eoh));
                  chk("resp_y", 64'(bus.resp_y), 64'(me.y));
                  chk("resp_neg", 64'(bus.resp_neg), 64'(me.neg));
                  chk("resp_err", 64'(bus.resp_err), 64'(me.err));
               end
            end else begin
               hold_v  = 1'b1;
               hold_rv = bus.resp_valid;
               hold_d  = {bus.resp_y, bus.resp_neg, bus.resp_err};
            end
         end
      end
   end

   initial begin
      int n;
      bus.req_valid  = '0;
      bus.req_x      = '0;
      bus.resp_ready = '0;
      sq_done = 1'b0;
      sq_y    = '0;
      sq_neg  = 1'b0;
      for (int i = 0; i < NR; i++) rx[i] = '0;

      step();
      step();
      check_reset_outputs("reset");
      drive_rst = 1'b0;
      step();

      // Directed cases: square, negative operand, hung core, done at timeout.
      pend[2] = 1'b1; rx[2] = 32'd144;        drain(200);
      pend[1] = 1'b1; rx[1] = 32'hFFFF_FFFB;  drain(200);
      force_mode = 1; pend[0] = 1'b1; rx[0] = 32'd400; drain(300);
      force_mode = 0; pend[3] = 1'b1; rx[3] = 32'd81;  drain(200);
      force_mode = 2; pend[1] = 1'b1; rx[1] = 32'd1000; drain(300);

      // Stall the response with resp_ready low while another request waits.
      force_mode = 0;
      rr_fixed   = '0;
      pend[2] = 1'b1; rx[2] = 32'd49;
      pend[0] = 1'b1; rx[0] = 32'd10000;
      n = 0;
      while (bus.resp_valid == '0 && n < 100) begin step(); n++; end
      chk("stall_resp_seen", 64'(n < 100), 64'd1);
      repeat (12) step();
      rr_fixed = '1;
      drain(300);

      // All requesters continuously valid: strict rotation.
      gen_mode = 2;
      repeat (200) step();
      gen_mode = 0;
      drain(300);

      // Random traffic, random back-pressure, random core behaviour.
      gen_mode   = 1;
      rr_mode    = 1;
      force_mode = -1;
      noise_en   = 1'b1;
      repeat (4000) step();
      gen_mode = 0;
      noise_en = 1'b0;
      drain(1000);

      // Reset while the core is hung in WAIT.
      rr_mode    = 0;
      rr_fixed   = '1;
      force_mode = 1;
      pend[0] = 1'b1; rx[0] = 32'd625;
      n = 0;
      while (!(exp_start_cyc > 0 && cyc == exp_start_cyc + 5) && n < 100) begin step(); n++; end
      drive_rst = 1'b1;
      step();
      check_reset_outputs("midrst");
      drive_rst  = 1'b0;
      force_mode = 0;
      pend = '1;
      for (int i = 0; i < NR; i++) rx[i] = 32'(i * 37 + 5);
      step();
      chk("ptr_after_reset", 64'(bus.req_ready), 64'd1);
      drain(500);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
